spi_slave_fsm: RTL and testbench

//  SPI peripheral controller sitting directly downstream of the input conditioners.

---
 rtl/spi_slave_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_fsm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// spi_slave_fsm
//
// SPI peripheral controller fed by the input conditioners. Every input is
// already synchronised to clk; SCLK is visible only as single-cycle rising and
// falling edge pulses. A transfer starts with one address/RW byte
// {addr[ADDR_W-1:0], rw}. It is followed either by a data byte that is written
// to memory (rw=0) or by a memory byte that is shifted out on MISO (rw=1).
// Both bytes are sent MSB first.
//
// Optional feature (compile-time macro SPI_BURST_EN):
//   When defined, the controller does not stop after one data byte. It
//   increments mem_addr (wrapping at 2^ADDR_W) and keeps writing or reading
//   consecutive bytes until chip select rises. When undefined, only one data
//   byte is handled per chip-select assertion and no address incrementer is
//   built.
//
// Parameters:
//   DATA_W  data byte width, which is also the address-phase length
//   ADDR_W  memory address width; must equal DATA_W-1
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active low
//   cs_cond    in   conditioned chip select, active low
//   sclk_pos   in   1-cycle pulse on each SCLK rising edge
//   sclk_neg   in   1-cycle pulse on each SCLK falling edge
//   mosi_cond  in   conditioned MOSI level
//   mem_rdata  in   memory read data, combinational from mem_addr
//   miso       out  serial read data, MSB first
//   miso_oe    out  MISO output enable
//   mem_addr   out  registered memory address
//   mem_wdata  out  registered write data
//   mem_we     out  single-cycle write strobe
//   busy       out  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module spi_slave_fsm #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_cond,
    input  logic              sclk_pos,
    input  logic              sclk_neg,
    input  logic              mosi_cond,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy
);

    // The counter has to hold DATA_W itself: in READ_SHIFT the controller
    // needs to know that the last rising edge has already been seen.
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        GET_ADDR     = 3'd1,
        READ_WAIT    = 3'd2,
        READ_SHIFT   = 3'd3,
        WRITE_SHIFT  = 3'd4,
        WRITE_COMMIT = 3'd5,
        DONE         = 3'd6
    } state_t;

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Shift register contents once the current MOSI bit has been sampled.
    logic [DATA_W-1:0] shift_in;
    assign shift_in = {shreg_q[DATA_W-2:0], mosi_cond};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (cs_cond) begin
            // Deselect aborts everything and overrides any coincident SCLK
            // edge. A write is lost unless WRITE_COMMIT has already been
            // reached.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = GET_ADDR;
                end

                GET_ADDR: begin
                    if (sclk_pos) begin
                        shreg_d = shift_in;
                        if (cnt_q == CNT_LAST) begin
                            mem_addr_d = shift_in[DATA_W-1:1];
                            state_d    = shift_in[0] ? READ_WAIT : WRITE_SHIFT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end

                READ_WAIT: begin
                    // mem_addr was loaded on the previous edge, so mem_rdata
                    // is valid now.
                    shreg_d = mem_rdata;
                    state_d = READ_SHIFT;
                end

                READ_SHIFT: begin
                    if (sclk_pos) begin
                        if (cnt_q != CNT_FULL) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (sclk_neg && (cnt_q != CNT_ZERO)) begin
                        // The falling edge left over from the address byte
                        // arrives with cnt_q == 0 and must not consume the MSB.
                        if (cnt_q == CNT_FULL) begin
`ifdef SPI_BURST_EN
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            state_d    = READ_WAIT;
`else
                            state_d    = DONE;
`endif
                        end else begin
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                WRITE_SHIFT: begin
                    if (sclk_pos) begin
                        shreg_d = shift_in;
                        if (cnt_q == CNT_LAST) begin
                            mem_wdata_d = shift_in;
                            state_d     = WRITE_COMMIT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end

                WRITE_COMMIT: begin
`ifdef SPI_BURST_EN
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    state_d    = WRITE_SHIFT;
`else
                    state_d    = DONE;
`endif
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Every phase counts from zero.
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end
    end

    assign miso_oe   = (state_q == READ_SHIFT);
    assign miso      = miso_oe & shreg_q[DATA_W-1];
    assign mem_we    = (state_q == WRITE_COMMIT);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_fsm
//
// Scoreboard bench for spi_slave_fsm with DATA_W=8. The bench acts as both the
// input conditioners and the SPI master: it drives SCLK as edge pulses with a
// half period of 5 clk. A small memory model answers mem_rdata.
// When a transfer is issued, the expected memory writes and MISO bits are
// queued. A negedge monitor pops the write queue whenever mem_we is seen. Read
// bits are popped after each read byte completes.
// -----------------------------------------------------------------------------
module tb_spi_slave_fsm;

    logic       clk;
    logic       rst_n;
    logic       cs_cond;
    logic       sclk_pos;
    logic       sclk_neg;
    logic       mosi_cond;
    logic [7:0] mem_rdata;
    logic       miso;
    logic       miso_oe;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;

    logic [7:0]  mem [0:127];
    logic [14:0] wq [$];
    logic        rq [$];
    int          nvec;
    int          nerr;

    spi_slave_fsm #(
        .DATA_W(8),
        .ADDR_W(7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_cond  (cs_cond),
        .sclk_pos (sclk_pos),
        .sclk_neg (sclk_neg),
        .mosi_cond(mosi_cond),
        .mem_rdata(mem_rdata),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .busy     (busy)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [14:0] e;
        if (rst_n && mem_we) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", 32'(mem_we), 32'd0);
            end else begin
                e = wq.pop_front();
                check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI byte (or part of one), MSB first. MISO is captured on the
    // rising-edge cycle, as a mode-0 master would capture it.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit final_neg,
                        output logic [7:0] rx, output logic oe_all);
        rx     = '0;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mosi_cond = tx[7-i];
            tick(4);
            sclk_pos = 1'b1;
            @(negedge clk);
            rx     = {rx[6:0], miso};
            oe_all = oe_all & miso_oe;
            @(posedge clk);
            #1;
            sclk_pos = 1'b0;
            if ((i < nbits - 1) || final_neg) begin
                tick(4);
                sclk_neg = 1'b1;
                tick(1);
                sclk_neg = 1'b0;
            end
        end
    endtask

    task automatic cs_low();
        cs_cond = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        cs_cond = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        logic       oe;
        wq.push_back({addr, data});
        cs_low();
        xfer({addr, 1'b0}, 8, 1'b1, rx, oe);
        xfer(data, 8, 1'b1, rx, oe);
        tick(2);
        check("wr_done", 32'(wq.size()), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
    endtask

    // Read one byte. CS rises right after the 8th rising edge, so the
    // one-cycle miso_oe turn-off latency can be observed.
    task automatic do_read(input logic [6:0] addr, input logic [7:0] exp);
        logic [7:0] rx;
        logic       oe;
        logic       b;
        for (int i = 7; i >= 0; i--) rq.push_back(exp[i]);
        cs_low();
        xfer({addr, 1'b1}, 8, 1'b1, rx, oe);
        check("rd_oe_on", 32'(miso_oe), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'(addr));
        xfer(8'h00, 8, 1'b0, rx, oe);
        check("rd_oe_all", 32'(oe), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            b = rq.pop_front();
            check("rd_bit", 32'(rx[i]), 32'(b));
        end
        cs_cond = 1'b1;
        @(negedge clk);
        check("rd_oe_hold", 32'(miso_oe), 32'd1);
        @(negedge clk);
        check("rd_oe_off", 32'(miso_oe), 32'd0);
        @(posedge clk);
        #1;
        tick(1);
        check("rd_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe;

        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        cs_cond   = 1'b1;
        sclk_pos  = 1'b0;
        sclk_neg  = 1'b0;
        mosi_cond = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3);

        // 1. Reset with random input activity.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            cs_cond   = 1'($urandom_range(0, 1));
            mosi_cond = 1'($urandom_range(0, 1));
            sclk_pos  = 1'($urandom_range(0, 1));
            sclk_neg  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_miso",    32'(miso),      32'd0);
            check("rst_oe",      32'(miso_oe),   32'd0);
            check("rst_addr",    32'(mem_addr),  32'd0);
            check("rst_wdata",   32'(mem_wdata), 32'd0);
            check("rst_we",      32'(mem_we),    32'd0);
            check("rst_busy",    32'(busy),      32'd0);
        end
        @(posedge clk);
        #1;
        cs_cond  = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        rst_n    = 1'b1;
        tick(2);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 2. Write 0xA5 to 0x0A; extra SCLK afterwards must not write again.
        do_write(7'h0A, 8'hA5);
        check("wr_wdata_hold", 32'(mem_wdata), 32'hA5);
`ifdef SPI_BURST_EN
        wq.push_back({7'h0B, 8'hFF});
`endif
        xfer(8'hFF, 8, 1'b1, rx, oe);
        tick(3);
        check("done_extra", 32'(wq.size()), 32'd0);
        cs_high();

        // 3. Reads of two distinct bytes.
        mem[7'h0A] = 8'h3C;
        do_read(7'h0A, 8'h3C);
        mem[7'h55] = 8'hC3;
        do_read(7'h55, 8'hC3);

        // 4. Aborted write after 5 data bits, then a complete write.
        cs_low();
        xfer(8'h14, 8, 1'b1, rx, oe);
        xfer(8'h77, 5, 1'b1, rx, oe);
        cs_high();
        check("abort_we", 32'(mem_we), 32'd0);
        do_write(7'h0A, 8'h5A);
        cs_high();

        // 5. CS rises on the same clk as the 8th data rising edge.
        cs_low();
        xfer(8'h14, 8, 1'b1, rx, oe);
        xfer(8'h99, 7, 1'b1, rx, oe);
        mosi_cond = 1'b1;
        tick(4);
        sclk_pos = 1'b1;
        cs_cond  = 1'b1;
        tick(1);
        sclk_pos = 1'b0;
        tick(3);
        check("cs_race_busy", 32'(busy), 32'd0);
        check("cs_race_we", 32'(mem_we), 32'd0);

        // 6. Two data bytes at address 0x7F; in burst mode the second wraps to 0.
        wq.push_back({7'h7F, 8'h11});
`ifdef SPI_BURST_EN
        wq.push_back({7'h00, 8'h22});
`endif
        cs_low();
        xfer(8'hFE, 8, 1'b1, rx, oe);
        xfer(8'h11, 8, 1'b1, rx, oe);
        xfer(8'h22, 8, 1'b1, rx, oe);
        tick(3);
        cs_high();

        tick(5);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
